// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, branch flushes,
// illegal-instruction exceptions, deferred interrupt injection and user/kernel mode.
module cpu_pipeline_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_funct,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_pc_super,
  input  logic       ex_memrd,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       irq,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       interrupt,
  output logic       exception,
  output logic [1:0] exc_sel,
  output logic       super_mode
);

  typedef enum logic {USER = 1'b0, SUPER = 1'b1} mode_t;

  localparam logic [1:0] SEL_NORMAL = 2'b00;
  localparam logic [1:0] SEL_IRQ    = 2'b01;
  localparam logic [1:0] SEL_EXC    = 2'b10;

  mode_t state;
  logic  pend;
  logic  illegal;
  logic  load_use;
  logic  safe;

  function automatic logic decode_illegal(input logic [5:0] op, input logic [5:0] fn);
    logic bad;
    bad = 1'b1;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A:   bad = 1'b0;
          default: bad = 1'b1;
        endcase
      end
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F,
      6'h23, 6'h2B: bad = 1'b0;
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign illegal  = id_valid & decode_illegal(id_opcode, id_funct);
  assign load_use = id_valid & ex_memrd & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign safe     = id_valid & ~ex_branch_taken & ~load_use & ~illegal &
                    ~id_pc_super & (state == USER);

  // Combinational sequencing; reset overrides everything so the pipe holds bubbles
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    interrupt  = 1'b0;
    exception  = 1'b0;
    exc_sel    = SEL_NORMAL;
    if (!reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (illegal) begin
      exception  = 1'b1;
      exc_sel    = SEL_EXC;
      ifid_flush = 1'b1;
    end else if (pend && safe) begin
      interrupt  = 1'b1;
      exc_sel    = SEL_IRQ;
      ifid_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Mode FSM and pending-interrupt latch; injection clears pend even if irq is still high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= USER;
      pend  <= 1'b0;
    end else begin
      if (interrupt)
        pend <= 1'b0;
      else if (irq)
        pend <= 1'b1;

      case (state)
        USER:    if (exception || interrupt) state <= SUPER;
        SUPER:   if (!exception && id_valid && !id_pc_super) state <= USER;
        default: state <= USER;
      endcase
    end
  end

  assign super_mode = (state == SUPER);

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Directed bench for cpu_pipeline_ctrl: per-cycle comparison against a rule-level
// model plus hand-computed literal checks on the key scenarios.
module tb_cpu_pipeline_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [5:0] id_funct;
  logic [4:0] id_rs, id_rt;
  logic       id_pc_super;
  logic       ex_memrd;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       irq;
  logic       pc_write, ifid_write, ifid_flush, idex_flush;
  logic       interrupt, exception, super_mode;
  logic [1:0] exc_sel;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_pipeline_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_pc_super(id_pc_super),
    .ex_memrd(ex_memrd), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .irq(irq),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .interrupt(interrupt), .exception(exception),
    .exc_sel(exc_sel), .super_mode(super_mode)
  );

  always #5 clk = ~clk;

  // Rule-level model: mode flag and pending flag only
  logic m_super = 1'b0, m_pend = 1'b0;
  logic n_super, n_pend;

  function automatic logic legal_enc(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A};
    return op inside {[6'h01:6'h0D], 6'h0F, 6'h23, 6'h2B};
  endfunction

  always @(negedge clk) begin
    logic [8:0] exp_v, act_v;
    logic ill, lu, take_irq, take_exc;
    ill = id_valid && !legal_enc(id_opcode, id_funct);
    lu  = id_valid && ex_memrd && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    take_irq = 1'b0;
    take_exc = 1'b0;
    // {pc_write, ifid_write, ifid_flush, idex_flush, interrupt, exception, exc_sel, super_mode}
    if (!reset)                exp_v = {8'b0011_0000, 1'b0};
    else if (ex_branch_taken)  exp_v = {8'b1111_0000, m_super};
    else if (ill) begin
      exp_v = {8'b1110_0110, m_super};
      take_exc = 1'b1;
    end else if (m_pend && id_valid && !id_pc_super && !m_super && !lu) begin
      exp_v = {8'b1110_1001, m_super};
      take_irq = 1'b1;
    end else if (lu)           exp_v = {8'b0001_0000, m_super};
    else                       exp_v = {8'b1100_0000, m_super};
    act_v = {pc_write, ifid_write, ifid_flush, idex_flush, interrupt, exception, exc_sel, super_mode};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t got %b want %b", $time, act_v, exp_v);
    end
    if (take_exc || take_irq)                     n_super = 1'b1;
    else if (m_super && id_valid && !id_pc_super) n_super = 1'b0;
    else                                          n_super = m_super;
    n_pend = take_irq ? 1'b0 : (irq ? 1'b1 : m_pend);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_super <= 1'b0;
      m_pend  <= 1'b0;
    end else begin
      m_super <= n_super;
      m_pend  <= n_pend;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  typedef struct { logic [5:0] op; logic [5:0] fn; logic ill; } enc_t;
  enc_t tbl[12] = '{
    '{6'h00, 6'h08, 1'b0}, '{6'h00, 6'h2A, 1'b0}, '{6'h00, 6'h28, 1'b1},
    '{6'h0E, 6'h00, 1'b1}, '{6'h0F, 6'h00, 1'b0}, '{6'h10, 6'h00, 1'b1},
    '{6'h23, 6'h00, 1'b0}, '{6'h24, 6'h00, 1'b1}, '{6'h2B, 6'h00, 1'b0},
    '{6'h01, 6'h00, 1'b0}, '{6'h0D, 6'h00, 1'b0}, '{6'h00, 6'h04, 1'b1}
  };

  initial begin
    reset = 1'b0; id_valid = 1'b1; id_opcode = 6'h00; id_funct = 6'h20;
    id_rs = 5'd1; id_rt = 5'd2; id_pc_super = 1'b0; ex_memrd = 1'b0;
    ex_rt = 5'd0; ex_branch_taken = 1'b0; irq = 1'b0;

    sample();
    chk("rst_pcw", {7'b0, pc_write}, 8'd0);
    chk("rst_flush", {6'b0, ifid_flush, idex_flush}, 8'b11);
    chk("rst_mode", {7'b0, super_mode}, 8'd0);
    tick(); reset = 1'b1;
    sample(); chk("norm_pcw", {7'b0, pc_write}, 8'd1);

    // load-use stall and its release
    tick(); ex_memrd = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    sample(); chk("lu_stall", {5'b0, pc_write, ifid_write, idex_flush}, 8'b001);
    tick(); ex_memrd = 1'b0; ex_rt = 5'd0;
    sample(); chk("lu_after", {5'b0, pc_write, ifid_write, idex_flush}, 8'b110);
    tick(); ex_memrd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    sample(); chk("lu_r0", {7'b0, pc_write}, 8'd1);

    // irq pulse, held off through a stall, then injected
    tick(); ex_memrd = 1'b0; id_rs = 5'd1; irq = 1'b1;
    sample(); chk("irq_lat", {7'b0, interrupt}, 8'd0);
    tick(); irq = 1'b0; ex_memrd = 1'b1; ex_rt = 5'd2;
    sample(); chk("irq_stall", {6'b0, interrupt, pc_write}, 8'b00);
    tick(); ex_memrd = 1'b0; ex_rt = 5'd0;
    sample(); chk("irq_take", {3'b0, interrupt, exc_sel, ifid_flush, idex_flush}, 8'b10110);
    tick(); id_pc_super = 1'b1; irq = 1'b1;
    sample(); chk("irq_mode", {7'b0, super_mode}, 8'd1);
    tick(); irq = 1'b0;
    sample(); chk("irq_masked", {7'b0, interrupt}, 8'd0);

    // return to user, then the pended irq fires
    tick(); id_pc_super = 1'b0;
    sample(); chk("ret_hold", {6'b0, super_mode, interrupt}, 8'b10);
    tick();
    sample(); chk("ret_irq", {4'b0, super_mode, interrupt, exc_sel}, 8'b0101);
    tick();
    sample(); chk("ret_super", {6'b0, super_mode, interrupt}, 8'b10);
    tick();
    sample(); chk("pend_clr", {6'b0, super_mode, interrupt}, 8'b00);

    // taken branch over an illegal instruction with pend set
    tick(); irq = 1'b1;
    sample();
    tick(); irq = 1'b0; ex_branch_taken = 1'b1; id_opcode = 6'h3F;
    sample(); chk("br_flush", {2'b0, pc_write, ifid_write, ifid_flush, idex_flush, interrupt, exception}, 8'b111100);
    tick(); ex_branch_taken = 1'b0; id_opcode = 6'h00;
    sample(); chk("br_pend_kept", {7'b0, interrupt}, 8'd1);
    tick(); tick();
    sample(); chk("br_ret", {7'b0, super_mode}, 8'd0);

    // illegal funct
    tick(); id_funct = 6'h01;
    sample(); chk("ill_funct", {2'b0, exception, exc_sel, ifid_flush, idex_flush, pc_write}, 8'b110101);
    tick(); id_funct = 6'h20;
    sample(); chk("ill_mode", {7'b0, super_mode}, 8'd1);
    tick();
    sample(); chk("ill_ret", {7'b0, super_mode}, 8'd0);

    // encoding table
    for (int i = 0; i < 12; i++) begin
      tick(); id_opcode = tbl[i].op; id_funct = tbl[i].fn;
      sample(); chk($sformatf("enc_%02h_%02h", tbl[i].op, tbl[i].fn), {7'b0, exception}, {7'b0, tbl[i].ill});
    end
    tick(); id_opcode = 6'h00; id_funct = 6'h20;
    tick();
    sample(); chk("enc_ret", {7'b0, super_mode}, 8'd0);

    // reset mid-handler with pend set
    tick(); id_funct = 6'h01;
    tick(); id_funct = 6'h20; id_pc_super = 1'b1; irq = 1'b1;
    sample(); chk("mid_super", {7'b0, super_mode}, 8'd1);
    tick(); irq = 1'b0; reset = 1'b0;
    #1 chk("rst_async", {3'b0, pc_write, ifid_write, ifid_flush, idex_flush, super_mode}, 8'b00110);
    sample();
    tick(); reset = 1'b1; id_pc_super = 1'b0;
    sample(); chk("rst_rel", {5'b0, super_mode, interrupt, pc_write}, 8'b001);
    tick();
    sample(); chk("rst_pend_lost", {7'b0, interrupt}, 8'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
